// File: rtl/vespa_decode_if.sv
// ----------------------------------------------------------------------------
// vespa_decode_if
// Handshake and payload bundle around the VESPA decode stage.
//   in_valid / in_ready        : fetch -> decode handshake
//   in_ir, in_pc               : instruction word and its PC
//   out_valid / out_ready      : decode -> execute handshake
//   out_ir, out_pc, out_x,
//   out_y, out_md, out_cond    : decoded, registered stage outputs
// Modports:
//   slave  : the decode stage itself
//   master : the surrounding pipeline / testbench
// ----------------------------------------------------------------------------
interface vespa_decode_if #(
    parameter int DW = 32
) ();
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_ir;
    logic [DW-1:0] in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_ir;
    logic [DW-1:0] out_pc;
    logic [DW-1:0] out_x;
    logic [DW-1:0] out_y;
    logic [DW-1:0] out_md;
    logic          out_cond;

    modport slave (
        input  in_valid, in_ir, in_pc, out_ready,
        output in_ready, out_valid, out_ir, out_pc, out_x, out_y, out_md, out_cond
    );

    modport master (
        output in_valid, in_ir, in_pc, out_ready,
        input  in_ready, out_valid, out_ir, out_pc, out_x, out_y, out_md, out_cond
    );
endinterface

// File: rtl/vespa_decode_stage.sv
// ----------------------------------------------------------------------------
// vespa_decode_stage
// Decode stage of the VESPA pipeline: selects register-file read addresses,
// builds the sign-extended immediate, forms the X/Y/MD operands, evaluates
// the branch condition, and registers everything toward execute behind a
// valid/ready handshake. A hlt instruction is issued and then parks the stage
// in HALTED until clr.
//
// Ports:
//   clk, clr          : clock, synchronous active-high reset
//   bus (slave)       : input/output handshakes and registered outputs
//   C, Z, N, V        : condition flags for branch evaluation
//   a1, a2            : register-file read addresses (combinational)
//   r1, r2            : register-file read data
//   fwd_we/addr/data  : writeback forwarding bus
//   flush             : discard held and incoming instruction
//   halted            : stage is in HALTED
//
// Build option:
//   VESPA_DECODE_FWD_EN : when defined, operands are bypassed from the
//                         writeback bus on an address match; otherwise the
//                         forwarding ports are accepted but ignored.
// ----------------------------------------------------------------------------
module vespa_decode_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          clr,
    vespa_decode_if.slave bus,
    input  logic          C,
    input  logic          Z,
    input  logic          N,
    input  logic          V,
    output logic [AW-1:0] a1,
    output logic [AW-1:0] a2,
    input  logic [DW-1:0] r1,
    input  logic [DW-1:0] r2,
    input  logic          fwd_we,
    input  logic [AW-1:0] fwd_addr,
    input  logic [DW-1:0] fwd_data,
    input  logic          flush,
    output logic          halted
);

    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_NOT = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6;
    localparam logic [4:0] OP_CMP = 5'd7;
    localparam logic [4:0] OP_BR  = 5'd8;
    localparam logic [4:0] OP_JMP = 5'd9;
    localparam logic [4:0] OP_LD  = 5'd10;
    localparam logic [4:0] OP_LDI = 5'd11;
    localparam logic [4:0] OP_LDX = 5'd12;
    localparam logic [4:0] OP_ST  = 5'd13;
    localparam logic [4:0] OP_STX = 5'd14;
    localparam logic [4:0] OP_HLT = 5'd31;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    // Sign-extension helpers for the four immediate field widths.
    function automatic logic [DW-1:0] sext16(input logic [15:0] v);
        return {{(DW-16){v[15]}}, v};
    endfunction

    function automatic logic [DW-1:0] sext17(input logic [16:0] v);
        return {{(DW-17){v[16]}}, v};
    endfunction

    function automatic logic [DW-1:0] sext22(input logic [21:0] v);
        return {{(DW-22){v[21]}}, v};
    endfunction

    function automatic logic [DW-1:0] sext23(input logic [22:0] v);
        return {{(DW-23){v[22]}}, v};
    endfunction

    // Instruction register fields are 5 bits; fit them to AW (AW <= 32).
    function automatic logic [AW-1:0] fit_addr(input logic [4:0] f);
        logic [31:0] w;
        w = {27'd0, f};
        return w[AW-1:0];
    endfunction

    // Branch condition table; codes 1, 14 and 15 never take.
    function automatic logic eval_cond(input logic [3:0] cc, input logic c_f,
                                       input logic z_f, input logic n_f,
                                       input logic v_f);
        logic r;
        case (cc)
            4'd0:    r = 1'b1;
            4'd2:    r = !c_f;
            4'd3:    r = c_f;
            4'd4:    r = !v_f;
            4'd5:    r = v_f;
            4'd6:    r = z_f;
            4'd7:    r = !z_f;
            4'd8:    r = (n_f == v_f);
            4'd9:    r = (n_f != v_f);
            4'd10:   r = !z_f && (n_f == v_f);
            4'd11:   r = z_f || (n_f != v_f);
            4'd12:   r = !n_f;
            4'd13:   r = n_f;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [0:0]    state_r;
    logic          out_valid_r;
    logic [31:0]   out_ir_r;
    logic [DW-1:0] out_pc_r;
    logic [DW-1:0] out_x_r;
    logic [DW-1:0] out_y_r;
    logic [DW-1:0] out_md_r;
    logic          out_cond_r;

    logic [4:0]    opc_s;
    logic          is_br_s;
    logic          use_imm_s;
    logic [DW-1:0] imm_s;
    logic [DW-1:0] op1_s;
    logic [DW-1:0] op2_s;
    logic [DW-1:0] x_s;
    logic [DW-1:0] y_s;
    logic          cond_s;
    logic          in_ready_s;
    logic          accept_s;

    assign opc_s = bus.in_ir[31:27];

    // Read addresses: stores take their data register from the rd field.
    always_comb begin
        a1 = fit_addr(bus.in_ir[21:17]);
        if ((opc_s == OP_ST) || (opc_s == OP_STX)) begin
            a2 = fit_addr(bus.in_ir[26:22]);
        end else begin
            a2 = fit_addr(bus.in_ir[15:11]);
        end
    end

    // Immediate selection; unlisted opcodes behave as nop and use no immediate.
    always_comb begin
        use_imm_s = 1'b0;
        is_br_s   = 1'b0;
        imm_s     = {DW{1'b0}};
        case (opc_s)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_NOT, OP_XOR, OP_CMP, OP_JMP: begin
                if (bus.in_ir[16]) begin
                    use_imm_s = 1'b1;
                    imm_s     = sext16(bus.in_ir[15:0]);
                end else begin
                    use_imm_s = 1'b0;
                end
            end
            OP_BR: begin
                is_br_s   = 1'b1;
                use_imm_s = 1'b1;
                imm_s     = sext23(bus.in_ir[22:0]);
            end
            OP_LD, OP_ST, OP_LDI: begin
                use_imm_s = 1'b1;
                imm_s     = sext22(bus.in_ir[21:0]);
            end
            OP_LDX, OP_STX: begin
                use_imm_s = 1'b1;
                imm_s     = sext17(bus.in_ir[16:0]);
            end
            default: begin
                use_imm_s = 1'b0;
            end
        endcase
    end

`ifdef VESPA_DECODE_FWD_EN
    // Writeback bypass: a same-cycle write to a read address wins over the file.
    always_comb begin
        if (fwd_we && (fwd_addr == a1)) begin
            op1_s = fwd_data;
        end else begin
            op1_s = r1;
        end
        if (fwd_we && (fwd_addr == a2)) begin
            op2_s = fwd_data;
        end else begin
            op2_s = r2;
        end
    end
`else
    logic unused_fwd_s;

    // Forwarding bus is present on the port list but has no effect here.
    always_comb begin
        op1_s        = r1;
        op2_s        = r2;
        unused_fwd_s = ^{fwd_we, fwd_addr, fwd_data};
    end
`endif

    // Operand muxing and branch outcome for the instruction on the input.
    always_comb begin
        if (is_br_s) begin
            x_s = bus.in_pc;
        end else begin
            x_s = op1_s;
        end
        if (use_imm_s) begin
            y_s = imm_s;
        end else begin
            y_s = op2_s;
        end
        cond_s = is_br_s && eval_cond(bus.in_ir[26:23], C, Z, N, V);
    end

    assign in_ready_s = (state_r == ST_RUN) && !flush && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    // Output register and RUN/HALTED state; priority clr > flush > accept > drain.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r     <= ST_RUN;
            out_valid_r <= 1'b0;
            out_ir_r    <= 32'd0;
            out_pc_r    <= {DW{1'b0}};
            out_x_r     <= {DW{1'b0}};
            out_y_r     <= {DW{1'b0}};
            out_md_r    <= {DW{1'b0}};
            out_cond_r  <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            out_ir_r    <= 32'd0;
            out_cond_r  <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_ir_r    <= bus.in_ir;
            out_pc_r    <= bus.in_pc;
            out_x_r     <= x_s;
            out_y_r     <= y_s;
            out_md_r    <= op2_s;
            out_cond_r  <= cond_s;
            if (opc_s == OP_HLT) begin
                state_r <= ST_HALTED;
            end else begin
                state_r <= state_r;
            end
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_ir_r    <= 32'd0;
            out_cond_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_ir    = out_ir_r;
    assign bus.out_pc    = out_pc_r;
    assign bus.out_x     = out_x_r;
    assign bus.out_y     = out_y_r;
    assign bus.out_md    = out_md_r;
    assign bus.out_cond  = out_cond_r;
    assign halted        = (state_r == ST_HALTED);

endmodule

// File: tb/tb_vespa_decode_stage.sv
module tb_vespa_decode_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          clr;
    logic          C, Z, N, V;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] r1, r2;
    logic          fwd_we;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
    logic          flush;
    logic          halted;

    int n_checks;
    int n_fail;

    vespa_decode_if #(.DW(DW)) bus ();

    vespa_decode_stage #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .clr      (clr),
        .bus      (bus),
        .C        (C),
        .Z        (Z),
        .N        (N),
        .V        (V),
        .a1       (a1),
        .a2       (a2),
        .r1       (r1),
        .r2       (r2),
        .fwd_we   (fwd_we),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .flush    (flush),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] IR_ADD  = 32'h08C2_1000; // add r3,r1,r2
    localparam logic [31:0] IR_BRZ  = 32'h437F_FFFF; // br cond 6, imm23 all ones
    localparam logic [31:0] IR_LDI  = 32'h5820_0000; // ldi imm22 = 0x200000
    localparam logic [31:0] IR_SUBI = 32'h1001_8001; // sub imm16 = 0x8001
    localparam logic [31:0] IR_OR   = 32'h1800_0000;
    localparam logic [31:0] IR_ST   = 32'h6A40_0010; // st, a2 = 9, imm = 0x10
    localparam logic [31:0] IR_UNK  = 32'hA001_1234; // opcode 20 -> nop
    localparam logic [31:0] IR_BR8  = 32'h4400_0005; // br N==V, imm 5
    localparam logic [31:0] IR_BR9  = 32'h4480_0005; // br N!=V, imm 5
    localparam logic [31:0] IR_HLT  = 32'hF800_0000;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr = 1'b1; flush = 1'b0;
        C = 1'b0; Z = 1'b0; N = 1'b0; V = 1'b0;
        r1 = 32'd0; r2 = 32'd0;
        fwd_we = 1'b0; fwd_addr = 5'd0; fwd_data = 32'd0;
        bus.in_valid = 1'b0; bus.in_ir = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b1;

        // Reset state
        tick();
        check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_ir", {32'd0, bus.out_ir}, 64'd0);
        check("rst_x", {32'd0, bus.out_x}, 64'd0);
        check("rst_pc", {32'd0, bus.out_pc}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);

        // add r3,r1,r2 with r1=5, r2=7
        clr = 1'b0;
        r1 = 32'd5; r2 = 32'd7;
        bus.in_valid = 1'b1; bus.in_ir = IR_ADD; bus.in_pc = 32'h40;
        #1;
        check("add_a1", {59'd0, a1}, 64'd1);
        check("add_a2", {59'd0, a2}, 64'd2);
        check("add_in_ready", {63'd0, bus.in_ready}, 64'd1);
        tick();
        check("add_valid", {63'd0, bus.out_valid}, 64'd1);
        check("add_x", {32'd0, bus.out_x}, 64'd5);
        check("add_y", {32'd0, bus.out_y}, 64'd7);
        check("add_md", {32'd0, bus.out_md}, 64'd7);
        check("add_ir", {32'd0, bus.out_ir}, {32'd0, IR_ADD});
        check("add_pc", {32'd0, bus.out_pc}, 64'h40);

        // branch on Z, taken, back-to-back with the add
        bus.in_ir = IR_BRZ; bus.in_pc = 32'h100; Z = 1'b1;
        tick();
        check("brz1_valid", {63'd0, bus.out_valid}, 64'd1);
        check("brz1_cond", {63'd0, bus.out_cond}, 64'd1);
        check("brz1_x", {32'd0, bus.out_x}, 64'h100);
        check("brz1_y", {32'd0, bus.out_y}, 64'hFFFF_FFFF);
        Z = 1'b0;
        tick();
        check("brz0_valid", {63'd0, bus.out_valid}, 64'd1);
        check("brz0_cond", {63'd0, bus.out_cond}, 64'd0);

        // execute stall for three cycles
        bus.out_ready = 1'b0;
        bus.in_ir = IR_LDI; bus.in_pc = 32'h104;
        #1;
        check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
            check("stall_ir", {32'd0, bus.out_ir}, {32'd0, IR_BRZ});
            check("stall_pc", {32'd0, bus.out_pc}, 64'h100);
            check("stall_in_ready2", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        tick();
        check("ldi_ir", {32'd0, bus.out_ir}, {32'd0, IR_LDI});
        check("ldi_y", {32'd0, bus.out_y}, 64'hFFE0_0000);
        check("ldi_pc", {32'd0, bus.out_pc}, 64'h104);
        bus.in_valid = 1'b0;
        tick();
        check("drain_valid", {63'd0, bus.out_valid}, 64'd0);
        check("drain_ir", {32'd0, bus.out_ir}, 64'd0);
        check("drain_pc_hold", {32'd0, bus.out_pc}, 64'h104);

        // flush with a held instruction and a pending input
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        bus.in_ir = IR_SUBI; bus.in_pc = 32'h108;
        tick();
        check("subi_valid", {63'd0, bus.out_valid}, 64'd1);
        check("subi_y", {32'd0, bus.out_y}, 64'hFFFF_8001);
        check("subi_x", {32'd0, bus.out_x}, 64'd5);
        flush = 1'b1; bus.in_ir = IR_OR;
        #1;
        check("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
        tick();
        check("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        check("flush_ir", {32'd0, bus.out_ir}, 64'd0);
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        check("post_flush_valid", {63'd0, bus.out_valid}, 64'd0);

        // store: data register from the rd field
        bus.in_valid = 1'b1; bus.in_ir = IR_ST; bus.in_pc = 32'h10C;
        #1;
        check("st_a2", {59'd0, a2}, 64'd9);
        tick();
        check("st_md", {32'd0, bus.out_md}, 64'd7);
        check("st_y", {32'd0, bus.out_y}, 64'h10);
        check("st_x", {32'd0, bus.out_x}, 64'd5);

        // writeback forwarding onto operand 1
        fwd_we = 1'b1; fwd_addr = 5'd1; fwd_data = 32'hDEAD; r1 = 32'd1;
        bus.in_ir = IR_ADD;
        tick();
`ifdef VESPA_DECODE_FWD_EN
        check("fwd_x", {32'd0, bus.out_x}, 64'hDEAD);
`else
        check("fwd_x", {32'd0, bus.out_x}, 64'd1);
`endif
        check("fwd_y", {32'd0, bus.out_y}, 64'd7);
        fwd_we = 1'b0;

        // unknown opcode decodes as nop: no immediate even with bit 16 set
        bus.in_ir = IR_UNK;
        tick();
        check("nop_y", {32'd0, bus.out_y}, 64'd7);
        check("nop_cond", {63'd0, bus.out_cond}, 64'd0);

        // signed-compare branch conditions with N=1, V=0
        N = 1'b1; V = 1'b0;
        bus.in_ir = IR_BR8; bus.in_pc = 32'h200;
        tick();
        check("br8_cond", {63'd0, bus.out_cond}, 64'd0);
        check("br8_x", {32'd0, bus.out_x}, 64'h200);
        check("br8_y", {32'd0, bus.out_y}, 64'd5);
        bus.in_ir = IR_BR9;
        tick();
        check("br9_cond", {63'd0, bus.out_cond}, 64'd1);

        // halt
        bus.in_ir = IR_HLT; bus.in_pc = 32'h300;
        tick();
        check("hlt_halted", {63'd0, halted}, 64'd1);
        check("hlt_valid", {63'd0, bus.out_valid}, 64'd1);
        check("hlt_ir", {32'd0, bus.out_ir}, {32'd0, IR_HLT});
        bus.in_ir = IR_ADD;
        #1;
        check("hlt_in_ready", {63'd0, bus.in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halted_hold", {63'd0, halted}, 64'd1);
            check("halted_valid", {63'd0, bus.out_valid}, 64'd0);
            check("halted_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_keeps_halt", {63'd0, halted}, 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0; bus.in_valid = 1'b0;
        #1;
        check("clr_halted", {63'd0, halted}, 64'd0);
        check("clr_valid", {63'd0, bus.out_valid}, 64'd0);
        check("clr_pc", {32'd0, bus.out_pc}, 64'd0);
        check("clr_y", {32'd0, bus.out_y}, 64'd0);
        check("clr_md", {32'd0, bus.out_md}, 64'd0);
        check("clr_in_ready", {63'd0, bus.in_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vespa_decode_stage.md
VESPA_DECODE_STAGE -- requirements
Module: vespa_decode_stage

Interface
REQ-001 Parameter DW, 32, datapath/PC width; SHALL be >= 32.
REQ-002 Parameter AW, 5, register-address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 in_valid/in_ready  input/output  1/1  decode-input handshake.
REQ-006 in_ir  input  32  instruction; in_pc  input  DW  its PC.
REQ-007 C, Z, N, V  input  1 each  condition flags.
REQ-008 a1, a2  output  AW each  register-file read addresses, combinational from in_ir.
REQ-009 r1, r2  input  DW each  register-file read data for a1/a2.
REQ-010 fwd_we, fwd_addr, fwd_data  input  1/AW/DW  writeback forwarding bus.
REQ-011 flush  input  1  discard the current and incoming instruction.
REQ-012 out_valid/out_ready  output/input  1/1  execute-side handshake.
REQ-013 out_ir  output  32; out_pc, out_x, out_y, out_md  output  DW each; out_cond  output  1  registered stage outputs.
REQ-014 halted  output  1  halt state indicator.

Function
REQ-015 Opcode in_ir[31:27]: 0 nop, 1 add, 2 sub, 3 or, 4 and, 5 not, 6 xor, 7 cmp, 8 br, 9 jmp, 10 ld, 11 ldi, 12 ldx, 13 st, 14 stx, 31 hlt; other values SHALL decode as nop.
REQ-016 a1 = in_ir[21:17]; a2 = in_ir[26:22] for st/stx, else in_ir[15:11] (zero-extended/truncated to AW).
REQ-017 Immediate, sign-extended to DW: ALU ops and jmp with in_ir[16]=1 -> in_ir[15:0]; br -> in_ir[22:0]; ld/st/ldi -> in_ir[21:0]; ldx/stx -> in_ir[16:0].
REQ-018 X operand = in_pc for br, else operand-1; Y operand = immediate when REQ-017 applies, else operand-2; MD = operand-2.
REQ-019 Branch condition in_ir[26:23]: 0 always, 1 never, 2 !C, 3 C, 4 !V, 5 V, 6 Z, 7 !Z, 8 N==V, 9 N!=V, 10 !Z&&N==V, 11 Z||N!=V, 12 !N, 13 N, 14-15 never; out_cond captures (br && cond) on acceptance, else 0.
REQ-020 in_ready = !halted && !flush && (!out_valid || out_ready).
REQ-021 Accept (in_valid && in_ready): all out_* registers load next edge, out_valid=1; latency one cycle.
REQ-022 out_valid && out_ready with no accept: out_valid=0, out_ir=0, out_cond=0; other outputs hold.
REQ-023 out_valid && !out_ready: all outputs hold stable (no accept possible).
REQ-024 flush=1: next edge out_valid=0, out_ir=0, out_cond=0; no accept; flush overrides in_valid and out_ready.
REQ-025 States RUN, HALTED: RUN->HALTED on accept of hlt (hlt itself still issued); HALTED holds until clr; flush does not leave HALTED.
REQ-026 Back-to-back accepts every cycle SHALL be sustained while out_ready=1.

Reset
REQ-027 clr=1 at an edge: out_valid=0, out_ir=0, out_pc/out_x/out_y/out_md=0, out_cond=0, state RUN; clr overrides flush and accept.
REQ-028 clr mid-handshake discards the held instruction; in_ready may assert the cycle after clr deasserts.

Configuration
REQ-029 Macro VESPA_DECODE_FWD_EN defined: operand-1 = fwd_data when fwd_we && fwd_addr==a1, else r1; operand-2 likewise vs a2.
REQ-030 VESPA_DECODE_FWD_EN undefined: operand-1=r1, operand-2=r2; fwd_* ports present but ignored.

Verification
REQ-031 clr then add r3,r1,r2 (r1=5, r2=7), out_ready=1 -> next cycle out_valid=1, out_x=5, out_y=7, out_ir=input IR.
REQ-032 br cond 6 imm23=0x7FFFFF, in_pc=0x100, Z=1 -> out_cond=1, out_x=0x100, out_y=all-ones; same with Z=0 -> out_cond=0.
REQ-033 Hold out_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs unchanged; release -> next instruction accepted one cycle later, none lost or duplicated.
REQ-034 flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0, out_ir=0, flushed input not accepted.
REQ-035 hlt accepted -> halted=1, in_ready=0 indefinitely; clr -> halted=0, all outputs 0.
REQ-036 FWD_EN defined: fwd_we=1, fwd_addr=a1, fwd_data=0xDEAD, r1=1 -> out_x=0xDEAD; undefined -> out_x=1.
